// File: rtl/tc_mtimer_ctrl_if.sv
// ---------------------------------------------------------------------------
// tc_mtimer_ctrl_if
//   Single-cycle 32-bit register bus used to configure and read the machine
//   timer controller.
//
//   req    : one-cycle access request
//   we     : 1 = write, 0 = read (sampled with req)
//   addr   : register word index
//   wdata  : write data
//   ack    : registered acknowledge, one cycle after each req
//   rdata  : read data, valid while ack=1, 0 otherwise
//
//   master modport : bus initiator (CPU side / testbench)
//   slave  modport : timer controller
// ---------------------------------------------------------------------------
interface tc_mtimer_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/tc_mtimer_ctrl.sv
// ---------------------------------------------------------------------------
// tc_mtimer_ctrl
//   64-bit machine timer: prescaled mtime counter, 64-bit compare register,
//   sticky pending flag and timer interrupt, configured over a single-cycle
//   32-bit register bus.
//
//   Optional feature macro: TC_MTIMER_AUTORELOAD_EN
//     Adds a 64-bit period register (addr 6/7) and CTRL bit3 autoreload,
//     which advances mtimecmp by period whenever pending sets.
//
//   Ports:
//     clk      : clock, all state changes on rising edge
//     rst      : synchronous active-high reset
//     bus      : register bus (slave modport of tc_mtimer_ctrl_if)
//     time_out : current mtime
//     tick     : one-cycle pulse following each mtime increment
//     irq      : pending & irq_en
//
//   Register map: 0 MTIME_LO, 1 MTIME_HI, 2 CMP_LO, 3 CMP_HI,
//                 4 CTRL {autoreload, pending, irq_en, enable},
//                 5 PRESCALE, 6 PERIOD_LO, 7 PERIOD_HI
// ---------------------------------------------------------------------------
module tc_mtimer_ctrl #(
    parameter logic [63:0] START_TIME     = 64'd0,
    parameter logic [31:0] RESET_PRESCALE = 32'd0,
    parameter logic [63:0] RESET_CMP      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    tc_mtimer_ctrl_if.slave      bus,
    output logic [63:0]          time_out,
    output logic                 tick,
    output logic                 irq
);

    localparam logic [2:0] A_MTIME_LO  = 3'd0;
    localparam logic [2:0] A_MTIME_HI  = 3'd1;
    localparam logic [2:0] A_CMP_LO    = 3'd2;
    localparam logic [2:0] A_CMP_HI    = 3'd3;
    localparam logic [2:0] A_CTRL      = 3'd4;
    localparam logic [2:0] A_PRESCALE  = 3'd5;
    localparam logic [2:0] A_PERIOD_LO = 3'd6;
    localparam logic [2:0] A_PERIOD_HI = 3'd7;

    typedef enum logic {STOPPED = 1'b0, RUN = 1'b1} run_state_t;

    run_state_t  state;
    logic [63:0] mtime;
    logic [63:0] cmp;
    logic [31:0] prescale;
    logic [31:0] count;
    logic        irq_en;
    logic        pending;
    logic [31:0] mtime_stage;
    logic [31:0] cmp_stage;
    logic [31:0] shadow_hi;
    logic        autoreload;

    logic        wr, rd;
    logic        wr_mtime_hi, wr_cmp_hi, wr_ctrl, wr_prescale;
    logic        fire, hit, clr_pend, set_pend, reload;
    logic [31:0] rd_mux;

`ifdef TC_MTIMER_AUTORELOAD_EN
    logic [63:0] period;
    logic [31:0] period_stage;
`endif

    assign wr          = bus.req &  bus.we;
    assign rd          = bus.req & ~bus.we;
    assign wr_mtime_hi = wr && (bus.addr == A_MTIME_HI);
    assign wr_cmp_hi   = wr && (bus.addr == A_CMP_HI);
    assign wr_ctrl     = wr && (bus.addr == A_CTRL);
    assign wr_prescale = wr && (bus.addr == A_PRESCALE);

    assign fire     = (state == RUN) && (count == prescale);
    assign hit      = (mtime >= cmp);
    // A clear in the same cycle as a compare hit wins for that cycle.
    assign clr_pend = (wr_ctrl && bus.wdata[2]) || wr_cmp_hi;
    assign set_pend = hit && !clr_pend;

`ifdef TC_MTIMER_AUTORELOAD_EN
    // Reload only on the 0->1 transition of pending, so cmp advances once
    // per interrupt rather than every cycle the compare holds.
    assign reload = autoreload && (period != 64'd0) && set_pend && !pending;
`else
    assign reload     = 1'b0;
    assign autoreload = 1'b0;
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (bus.addr)
            A_MTIME_LO:  rd_mux = mtime[31:0];
            A_MTIME_HI:  rd_mux = shadow_hi;
            A_CMP_LO:    rd_mux = cmp[31:0];
            A_CMP_HI:    rd_mux = cmp[63:32];
            A_CTRL:      rd_mux = {28'd0, autoreload, pending, irq_en, state == RUN};
            A_PRESCALE:  rd_mux = prescale;
`ifdef TC_MTIMER_AUTORELOAD_EN
            A_PERIOD_LO: rd_mux = period[31:0];
            A_PERIOD_HI: rd_mux = period[63:32];
`endif
            default:     rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STOPPED;
            mtime       <= START_TIME;
            cmp         <= RESET_CMP;
            prescale    <= RESET_PRESCALE;
            count       <= 32'd0;
            irq_en      <= 1'b0;
            pending     <= 1'b0;
            mtime_stage <= 32'd0;
            cmp_stage   <= 32'd0;
            shadow_hi   <= 32'd0;
            tick        <= 1'b0;
            bus.ack     <= 1'b0;
            bus.rdata   <= 32'd0;
`ifdef TC_MTIMER_AUTORELOAD_EN
            autoreload   <= 1'b0;
            period       <= 64'd0;
            period_stage <= 32'd0;
`endif
        end else begin
            // Bus response
            bus.ack   <= bus.req;
            bus.rdata <= rd ? rd_mux : 32'd0;
            // LO read snapshots the upper half so a following HI read is coherent
            if (rd && bus.addr == A_MTIME_LO)
                shadow_hi <= mtime[63:32];

            // Prescaler / counter; a software mtime commit overrides the tick
            if (wr_mtime_hi) begin
                mtime <= {bus.wdata, mtime_stage};
                count <= 32'd0;
            end else if (fire) begin
                mtime <= mtime + 64'd1;
                count <= 32'd0;
            end else if (state == RUN) begin
                count <= count + 32'd1;
            end
            if (wr_prescale) begin
                prescale <= bus.wdata;
                count    <= 32'd0;
            end
            tick <= fire && !wr_mtime_hi;

            // Staging for 64-bit writes
            if (wr && bus.addr == A_MTIME_LO) mtime_stage <= bus.wdata;
            if (wr && bus.addr == A_CMP_LO)   cmp_stage   <= bus.wdata;

            // Compare register: software commit, else autoreload advance
            if (wr_cmp_hi)
                cmp <= {bus.wdata, cmp_stage};
`ifdef TC_MTIMER_AUTORELOAD_EN
            else if (reload)
                cmp <= cmp + period;
`endif

            // Sticky pending
            if (clr_pend)
                pending <= 1'b0;
            else if (set_pend)
                pending <= 1'b1;

            if (wr_ctrl) begin
                state  <= bus.wdata[0] ? RUN : STOPPED;
                irq_en <= bus.wdata[1];
`ifdef TC_MTIMER_AUTORELOAD_EN
                autoreload <= bus.wdata[3];
`endif
            end

`ifdef TC_MTIMER_AUTORELOAD_EN
            if (wr && bus.addr == A_PERIOD_LO) period_stage <= bus.wdata;
            if (wr && bus.addr == A_PERIOD_HI) period <= {bus.wdata, period_stage};
`endif
        end
    end

    assign time_out = mtime;
    assign irq      = pending & irq_en;

endmodule

// File: tb/tb_tc_mtimer_ctrl.sv
// Directed bench for tc_mtimer_ctrl. Stimulus and sampling happen on the
// falling edge; each bus access occupies exactly one clock.
module tb_tc_mtimer_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] time_out;
    logic        tick;
    logic        irq;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] rv;

    tc_mtimer_ctrl_if bus_if ();

    tc_mtimer_ctrl #(
        .START_TIME     (64'd100),
        .RESET_PRESCALE (32'd0),
        .RESET_CMP      (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if.slave),
        .time_out (time_out),
        .tick     (tick),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge; returns at the next falling edge.
    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        bus_if.req   = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        @(negedge clk);
        bus_if.req = 1'b0;
        bus_if.we  = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        bus_if.req   = 1'b1;
        bus_if.we    = 1'b0;
        bus_if.addr  = a;
        bus_if.wdata = 32'd0;
        @(negedge clk);
        d = bus_if.rdata;
        chk("rd_ack", {63'd0, bus_if.ack}, 64'd1);
        bus_if.req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        bus_if.req   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = 3'd0;
        bus_if.wdata = 32'd0;

        // 1. Reset and stopped hold
        idle(2);
        chk("rst_time", time_out, 64'd100);
        chk("rst_irq",  {63'd0, irq}, 64'd0);
        chk("rst_ack",  {63'd0, bus_if.ack}, 64'd0);
        chk("rst_tick", {63'd0, tick}, 64'd0);
        rst = 1'b0;
        idle(10);
        chk("stopped_hold", time_out, 64'd100);
        chk("idle_ack", {63'd0, bus_if.ack}, 64'd0);

        // 2. Prescale 3 -> one increment every 4 cycles
        bus_wr(3'd5, 32'd3);
        bus_wr(3'd4, 32'd1);
        idle(3);
        chk("pre_t3", time_out, 64'd100);
        idle(1);
        chk("pre_t4", time_out, 64'd101);
        chk("pre_tick", {63'd0, tick}, 64'd1);
        idle(1);
        chk("pre_notick", {63'd0, tick}, 64'd0);
        idle(14);
        chk("pre_t19", time_out, 64'd104);
        idle(1);
        chk("pre_t20", time_out, 64'd105);
        bus_rd(3'd5, rv);
        chk("rd_prescale", {32'd0, rv}, 64'd3);

        // 3. Compare / irq / clear
        bus_wr(3'd4, 32'd0);
        bus_wr(3'd5, 32'd0);
        bus_wr(3'd2, 32'd110);
        bus_wr(3'd3, 32'd0);
        bus_wr(3'd4, 32'd3);
        chk("cmp_start", time_out, 64'd105);
        idle(5);
        chk("cmp_t110", time_out, 64'd110);
        chk("cmp_irq_lo", {63'd0, irq}, 64'd0);
        idle(1);
        chk("cmp_irq_hi", {63'd0, irq}, 64'd1);
        bus_wr(3'd4, 32'd7);
        chk("cmp_cleared", {63'd0, irq}, 64'd0);
        idle(1);
        chk("cmp_reassert", {63'd0, irq}, 64'd1);
        bus_rd(3'd4, rv);
        chk("rd_ctrl", {32'd0, rv}, 64'd7);

        // 4. 64-bit coherent read around the 32-bit carry
        bus_wr(3'd5, 32'd3);
        bus_wr(3'd0, 32'hFFFF_FFFF);
        bus_wr(3'd1, 32'd0);
        bus_rd(3'd0, rv);
        chk("lo_before_wrap", {32'd0, rv}, 64'hFFFF_FFFF);
        idle(2);
        bus_rd(3'd1, rv);
        chk("hi_shadow_old", {32'd0, rv}, 64'd0);
        bus_rd(3'd0, rv);
        chk("lo_after_wrap", {32'd0, rv}, 64'd0);
        bus_rd(3'd1, rv);
        chk("hi_after_wrap", {32'd0, rv}, 64'd1);

        // 5. MTIME_HI commit coinciding with a tick
        bus_wr(3'd0, 32'h0000_1234);
        bus_wr(3'd1, 32'd5);
        chk("commit_val",  time_out, 64'h5_0000_1234);
        chk("commit_tick", {63'd0, tick}, 64'd0);
        idle(3);
        chk("commit_hold", time_out, 64'h5_0000_1234);
        idle(1);
        chk("commit_next", time_out, 64'h5_0000_1235);
        chk("commit_ntick", {63'd0, tick}, 64'd1);

`ifdef TC_MTIMER_AUTORELOAD_EN
        // 6. Autoreload periodic compare
        bus_wr(3'd4, 32'd0);
        bus_wr(3'd5, 32'd0);
        bus_wr(3'd0, 32'd0);
        bus_wr(3'd1, 32'd0);
        bus_wr(3'd2, 32'd10);
        bus_wr(3'd3, 32'd0);
        bus_wr(3'd6, 32'd5);
        bus_wr(3'd7, 32'd0);
        bus_wr(3'd4, 32'hB);
        chk("ar_start_irq", {63'd0, irq}, 64'd0);
        idle(10);
        chk("ar_t10", time_out, 64'd10);
        idle(1);
        chk("ar_irq1", {63'd0, irq}, 64'd1);
        bus_rd(3'd2, rv);
        chk("ar_cmp15", {32'd0, rv}, 64'd15);
        bus_wr(3'd4, 32'hF);
        idle(3);
        bus_rd(3'd2, rv);
        chk("ar_cmp20", {32'd0, rv}, 64'd20);
        chk("ar_irq2", {63'd0, irq}, 64'd1);
`else
        bus_wr(3'd7, 32'hDEAD_BEEF);
        bus_rd(3'd6, rv);
        chk("period_lo_zero", {32'd0, rv}, 64'd0);
        bus_rd(3'd7, rv);
        chk("period_hi_zero", {32'd0, rv}, 64'd0);
        bus_wr(3'd4, 32'hB);
        bus_rd(3'd4, rv);
        chk("ctrl_no_bit3", {32'd0, rv & 32'h9}, 64'd1);
`endif

        // Mid-operation reset drops in-flight ack
        bus_if.req  = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = 3'd0;
        rst         = 1'b1;
        @(negedge clk);
        bus_if.req = 1'b0;
        rst        = 1'b0;
        chk("rst2_ack",  {63'd0, bus_if.ack}, 64'd0);
        chk("rst2_time", time_out, 64'd100);
        chk("rst2_irq",  {63'd0, irq}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
